// File: rtl/uart_loader_if.sv
// Bundle of the loader's UART FIFO, memory-write and go/status signals.
// Latency: none (wiring only).
// Backpressure: rx_pop/rx_ack, tx_available/tx_ack and mem_valid/mem_ready handshakes.
interface uart_loader_if;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        rx_ack;
    logic        tx_available;
    logic [7:0]  tx_data;
    logic        tx_ack;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic        go_valid;
    logic [31:0] go_addr;
    logic        busy;

    // Loader side.
    modport master (
        input  rx_data, rx_ack, tx_ack, mem_ready,
        output rx_pop, tx_available, tx_data, mem_valid, mem_addr, mem_wdata,
               mem_wstrb, go_valid, go_addr, busy
    );

    // UART FIFO / memory / core side.
    modport slave (
        output rx_data, rx_ack, tx_ack, mem_ready,
        input  rx_pop, tx_available, tx_data, mem_valid, mem_addr, mem_wdata,
               mem_wstrb, go_valid, go_addr, busy
    );
endinterface

// File: rtl/uart_loader.sv
// Serial program loader: decodes WRITE/GO frames from the UART RX FIFO into byte writes and a go pulse.
// Latency: one byte per rx_ack; each payload byte costs >=2 cycles (DATA + WRITE); reply one cycle after last byte.
// Backpressure: rx_pop drops while writing or replying; write and reply hold stable until mem_ready / tx_ack.
module uart_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    uart_loader_if.master bus
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_CSUM, S_REPLY, S_GO
    } state_t;

    state_t        state_q, state_d;
    logic          kind_go_q, kind_go_d;   // 1: GO frame, 0: WRITE or rejected byte
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   len_q, len_d;           // payload bytes still to write
    logic [1:0]    idx_q, idx_d;           // byte index inside ADDR / LEN fields
    logic [7:0]    byte_q, byte_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    tx_q, tx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   go_addr_q, go_addr_d;

    logic pop_st, counting, rx_take, timed_out;

    assign pop_st   = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    // The inter-byte timer only runs where we wait on the sender, never while we stall ourselves.
    assign counting = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
    assign rx_take  = bus.rx_ack && pop_st;

    // Next-state, field capture and inter-byte timeout.
    always_comb begin
        state_d   = state_q;
        kind_go_d = kind_go_q;
        addr_d    = addr_q;
        len_d     = len_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        csum_d    = csum_q;
        tx_d      = tx_q;
        go_addr_d = go_addr_q;
        tmo_d     = '0;
        timed_out = 1'b0;

        // A byte in the same cycle as expiry wins: rx_take keeps the counter at zero.
        if (counting && !rx_take) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timed_out = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rx_take) begin
                    idx_d = 2'd0;
                    if (bus.rx_data == 8'h57) begin
                        kind_go_d = 1'b0;
                        state_d   = S_ADDR;
                    end else if (bus.rx_data == 8'h47) begin
                        kind_go_d = 1'b1;
                        state_d   = S_ADDR;
                    end else begin
                        kind_go_d = 1'b0;
                        tx_d      = 8'h3F;
                        state_d   = S_REPLY;
                    end
                end
            end
            S_ADDR: begin
                if (rx_take) begin
                    addr_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (kind_go_q) begin
                            tx_d    = 8'h06;
                            state_d = S_REPLY;
                        end else begin
                            state_d = S_LEN;
                        end
                    end
                end
            end
            S_LEN: begin
                if (rx_take) begin
                    csum_d = 8'h00;
                    if (idx_q == 2'd0) begin
                        len_d[7:0] = bus.rx_data;
                        idx_d      = 2'd1;
                    end else begin
                        len_d[15:8] = bus.rx_data;
                        idx_d       = 2'd0;
                        state_d     = ({bus.rx_data, len_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_take) begin
                    byte_d  = bus.rx_data;
                    csum_d  = csum_q + bus.rx_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.mem_ready) begin
                    addr_d  = addr_q + 32'd1;
                    len_d   = len_q - 16'd1;
                    state_d = (len_q == 16'd1) ? S_CSUM : S_DATA;
                end
            end
            S_CSUM: begin
                if (rx_take) begin
                    tx_d    = (bus.rx_data == csum_q) ? 8'h06 : 8'h15;
                    state_d = S_REPLY;
                end
            end
            S_REPLY: begin
                if (bus.tx_ack) begin
                    if (kind_go_q) begin
                        // Publish the entry address together with the go pulse.
                        go_addr_d = addr_q;
                        state_d   = S_GO;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_GO: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (timed_out) begin
            state_d = S_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            kind_go_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            byte_q    <= '0;
            csum_q    <= '0;
            tx_q      <= '0;
            tmo_q     <= '0;
            go_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            kind_go_q <= kind_go_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            csum_q    <= csum_d;
            tx_q      <= tx_d;
            tmo_q     <= tmo_d;
            go_addr_q <= go_addr_d;
        end
    end

    // Outputs come from registered state only; rst forces all requests low while asserted.
    assign bus.rx_pop       = pop_st && !rst;
    assign bus.tx_available = (state_q == S_REPLY) && !rst;
    assign bus.tx_data      = tx_q;
    assign bus.mem_valid    = (state_q == S_WRITE) && !rst;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = {4{byte_q}};
    assign bus.mem_wstrb    = 4'b0001 << addr_q[1:0];
    assign bus.go_valid     = (state_q == S_GO) && !rst;
    assign bus.go_addr      = go_addr_q;
    assign bus.busy         = (state_q != S_IDLE) && !rst;
endmodule

// File: tb/tb_uart_loader.sv
// Randomised + directed bench for uart_loader with a frame-level reference model and scoreboard.
// Latency: expectations are order-based, not cycle-based.
// Backpressure: randomised rx gaps, mem_ready and tx_ack, plus directed long stalls.
module tb_uart_loader;
    localparam int TMO = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_loader_if bus ();

    uart_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         exp_wr[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_go[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  pl[$];
    logic        rx_have = 1'b0;
    logic [7:0]  rx_head = 8'h00;
    bit          hold_mem = 1'b0;
    bit          hold_tx = 1'b0;
    int          gap_max = 0;

    assign bus.rx_ack  = bus.rx_pop & rx_have;
    assign bus.rx_data = rx_head;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%h required=nothing", name, act);
    endtask

    // ---------------- reference model: frame encoder + expected responses ----------------
    task automatic send_write(input logic [31:0] addr, input bit use_csum, input logic [7:0] csum_in);
        logic [7:0]  sum;
        logic [7:0]  cs;
        logic [31:0] a;
        logic [15:0] len;
        wr_t         w;
        sum = 8'h00;
        a   = addr;
        len = 16'(pl.size());
        rx_q.push_back(8'h57);
        for (int i = 0; i < 4; i++) rx_q.push_back(addr[8*i +: 8]);
        rx_q.push_back(len[7:0]);
        rx_q.push_back(len[15:8]);
        foreach (pl[i]) begin
            rx_q.push_back(pl[i]);
            sum     = sum + pl[i];
            w.addr  = a;
            w.strb  = 4'b0001 << a[1:0];
            w.wdata = {4{pl[i]}};
            exp_wr.push_back(w);
            a = a + 32'd1;
        end
        cs = use_csum ? csum_in : sum;
        rx_q.push_back(cs);
        exp_tx.push_back((cs == sum) ? 8'h06 : 8'h15);
    endtask

    task automatic send_go(input logic [31:0] addr);
        rx_q.push_back(8'h47);
        for (int i = 0; i < 4; i++) rx_q.push_back(addr[8*i +: 8]);
        exp_tx.push_back(8'h06);
        exp_go.push_back(addr);
    endtask

    task automatic send_junk(input logic [7:0] b);
        rx_q.push_back(b);
        exp_tx.push_back(8'h3F);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((rx_q.size() != 0 || exp_wr.size() != 0 || exp_tx.size() != 0 ||
                exp_go.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) flag({name, "_drain_timeout"}, 32'(n));
        check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_mem_valid(input string name);
        int n = 0;
        while (!bus.mem_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) flag({name, "_no_mem_valid"}, 32'(n));
    endtask

    // ---------------- RX FIFO model with random inter-byte gaps ----------------
    initial begin
        logic take;
        int   gap = 0;
        forever begin
            @(negedge clk);
            take = bus.rx_ack;
            @(posedge clk);
            #1;
            if (take && rx_q.size() != 0) begin
                void'(rx_q.pop_front());
                gap = $urandom_range(gap_max, 0);
            end else if (gap > 0) begin
                gap--;
            end
            rx_have = (gap == 0) && (rx_q.size() != 0);
            rx_head = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        end
    end

    // ---------------- random mem_ready / tx_ack ----------------
    initial begin
        bus.mem_ready = 1'b0;
        bus.tx_ack    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = hold_mem ? 1'b0 : ($urandom_range(3, 0) != 0);
            bus.tx_ack    = hold_tx  ? 1'b0 : ($urandom_range(2, 0) != 0);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic        pv_mem = 1'b0, pv_tx = 1'b0, p_go = 1'b0;
    logic [31:0] p_addr, p_wdata;
    logic [7:0]  p_txd;

    always @(negedge clk) begin
        wr_t w;
        if (!rst) begin
            if (pv_mem) begin
                check("mem_hold_valid", 32'(bus.mem_valid), 32'd1);
                check("mem_hold_addr", bus.mem_addr, p_addr);
                check("mem_hold_wdata", bus.mem_wdata, p_wdata);
            end
            if (pv_tx) begin
                check("tx_hold_valid", 32'(bus.tx_available), 32'd1);
                check("tx_hold_data", 32'(bus.tx_data), 32'(p_txd));
            end
            if (bus.mem_valid) check("rx_pop_in_write", 32'(bus.rx_pop), 32'd0);
            if (bus.tx_available) check("rx_pop_in_reply", 32'(bus.rx_pop), 32'd0);
            if (bus.mem_valid && bus.mem_ready) begin
                if (exp_wr.size() == 0) begin
                    flag("unexpected_write", bus.mem_addr);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", bus.mem_addr, w.addr);
                    check("wr_strb", 32'(bus.mem_wstrb), 32'(w.strb));
                    check("wr_data", bus.mem_wdata, w.wdata);
                end
            end
            if (bus.tx_available && bus.tx_ack) begin
                if (exp_tx.size() == 0) flag("unexpected_reply", 32'(bus.tx_data));
                else check("reply_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
            end
            if (bus.go_valid) begin
                check("go_pulse_width", 32'(p_go), 32'd0);
                if (exp_go.size() == 0) flag("unexpected_go", bus.go_addr);
                else check("go_addr", bus.go_addr, exp_go.pop_front());
            end
        end
        pv_mem  = !rst && bus.mem_valid && !bus.mem_ready;
        pv_tx   = !rst && bus.tx_available && !bus.tx_ack;
        p_go    = !rst && bus.go_valid;
        p_addr  = bus.mem_addr;
        p_wdata = bus.mem_wdata;
        p_txd   = bus.tx_data;
    end

    // Hard stop guard: never reached in a healthy run.
    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  jb;
        logic [31:0] ra;
        int          sel;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_pop", 32'(bus.rx_pop), 32'd0);
        check("rst_tx_available", 32'(bus.tx_available), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rst_go_valid", 32'(bus.go_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_go_addr", bus.go_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_rx_pop", 32'(bus.rx_pop), 32'd1);

        // Basic three-byte write, correct and wrong checksum.
        pl = '{8'hAA, 8'hBB, 8'hCC};
        send_write(32'h100, 1'b1, 8'h31);
        wait_done("write_ok", 2000);
        send_write(32'h100, 1'b1, 8'h00);
        wait_done("write_badcsum", 2000);

        // Long memory stall on the first write: held request, no pop, no timeout.
        hold_mem = 1'b1;
        pl = '{8'h11, 8'h22};
        send_write(32'h200, 1'b0, 8'h00);
        wait_mem_valid("stall");
        repeat (2 * TMO) begin
            @(negedge clk);
            check("stall_mem_valid", 32'(bus.mem_valid), 32'd1);
            check("stall_mem_addr", bus.mem_addr, 32'h200);
        end
        hold_mem = 1'b0;
        wait_done("stall", 2000);

        // GO frame with a held reply.
        hold_tx = 1'b1;
        send_go(32'h8000_0000);
        begin
            int n = 0;
            while (!bus.tx_available && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) flag("go_no_reply", 32'(n));
        end
        repeat (10) begin
            @(negedge clk);
            check("txhold_available", 32'(bus.tx_available), 32'd1);
            check("txhold_data", 32'(bus.tx_data), 32'h06);
            check("txhold_no_go", 32'(bus.go_valid), 32'd0);
        end
        hold_tx = 1'b0;
        wait_done("go", 2000);
        repeat (5) @(negedge clk);
        check("go_addr_held", bus.go_addr, 32'h8000_0000);

        // Unknown command byte.
        send_junk(8'h41);
        wait_done("junk", 2000);

        // Address wrap across 0xFFFFFFFF.
        pl = '{8'h11, 8'h22};
        send_write(32'hFFFF_FFFF, 1'b1, 8'h33);
        wait_done("wrap", 2000);

        // Zero-length write.
        pl.delete();
        send_write(32'h0, 1'b1, 8'h00);
        wait_done("len0", 2000);

        // Truncated frame: abort after TMO idle cycles with no reply.
        gap_max = 0;
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h01);
        begin
            int n = 0;
            while (rx_q.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (n >= 500) flag("tmo_not_consumed", 32'(n));
        end
        repeat (TMO - 20) @(negedge clk);
        check("tmo_still_busy", 32'(bus.busy), 32'd1);
        repeat (30) @(negedge clk);
        check("tmo_aborted", 32'(bus.busy), 32'd0);
        check("tmo_rx_pop", 32'(bus.rx_pop), 32'd1);

        // Reset while a write is pending.
        hold_mem = 1'b1;
        pl = '{8'h55};
        send_write(32'h300, 1'b0, 8'h00);
        wait_mem_valid("rstwr");
        @(posedge clk);
        #1 rst = 1'b1;
        rx_q.delete();
        exp_wr.delete();
        exp_tx.delete();
        exp_go.delete();
        @(negedge clk);
        check("rstwr_mem_valid_in_rst", 32'(bus.mem_valid), 32'd0);
        @(negedge clk);
        check("rstwr_go_addr", bus.go_addr, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        hold_mem = 1'b0;
        @(negedge clk);
        check("rstwr_mem_valid", 32'(bus.mem_valid), 32'd0);
        check("rstwr_busy", 32'(bus.busy), 32'd0);
        check("rstwr_tx", 32'(bus.tx_available), 32'd0);

        // Random back-to-back frames.
        gap_max = 3;
        repeat (40) begin
            sel = $urandom_range(7, 0);
            if (sel <= 4) begin
                pl.delete();
                repeat ($urandom_range(6, 0)) pl.push_back(8'($urandom));
                ra = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3, 0))) : $urandom;
                if ($urandom_range(3, 0) == 0) send_write(ra, 1'b1, 8'($urandom));
                else send_write(ra, 1'b0, 8'h00);
            end else if (sel == 5) begin
                send_go($urandom);
            end else begin
                jb = 8'($urandom);
                while (jb == 8'h57 || jb == 8'h47) jb = jb + 8'd1;
                send_junk(jb);
            end
        end
        wait_done("random", 20000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Byte-stream command engine on the client side of the `uart` FIFO interface.
- Consumes bytes from the UART RX pop port, decodes a framed write/go protocol, and issues byte writes to memory.
- Returns a one-byte status through the UART TX push port.
- Sits between `uart` and the core's memory bus; used to load a program image over serial, then release the core at an entry address.

Parameters:
- TIMEOUT_CYCLES, 1000000, max clk cycles allowed between consecutive frame bytes before the frame is aborted (minimum 2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_data  in  8  head byte of UART RX FIFO; valid when rx_ack=1
- rx_pop  out  1  request to consume an RX byte
- rx_ack  in  1  byte consumed this cycle (rx_pop && fifo not empty)
- tx_available  out  1  tx_data is offered to UART TX FIFO
- tx_data  out  8  status byte to send
- tx_ack  in  1  byte accepted this cycle
- mem_valid  out  1  memory write request
- mem_addr  out  32  byte address
- mem_wdata  out  32  write byte replicated on all 4 lanes
- mem_wstrb  out  4  one-hot lane select = 1 << mem_addr[1:0]
- mem_ready  in  1  write accepted this cycle (mem_valid && mem_ready)
- go_valid  out  1  one-cycle pulse: jump to go_addr
- go_addr  out  32  entry address; held until next GO frame or reset
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; rx_pop=0, tx_available=0, mem_valid=0, go_valid=0, busy=0 while rst is high.
  - go_addr=0, checksum=0, timeout counter=0.
  - Reset mid-frame or mid-write drops everything immediately; mem_valid and tx_available deassert the next cycle.
- Byte consumption: a byte is taken only in a cycle with rx_ack=1. rx_pop=1 exactly in IDLE, ADDR, LEN, DATA and CSUM; otherwise rx_pop=0 (backpressure).
- Frames (multi-byte fields little-endian):
  - WRITE: 0x57, addr[4], len[2], payload[len], csum.
  - GO: 0x47, addr[4].
- State machine:
  - IDLE:
    - 0x57 -> ADDR (kind=W).
    - 0x47 -> ADDR (kind=G).
    - Any other byte -> REPLY with 0x3F.
  - ADDR: collects 4 bytes into addr. Then:
    - kind=G -> REPLY 0x06, then GO.
    - kind=W -> LEN.
  - LEN: collects 2 bytes into remaining count and clears checksum. Then:
    - len=0 -> CSUM.
    - otherwise -> DATA.
  - DATA: on byte b, latch b, checksum += b (mod 256) -> WRITE.
  - WRITE: mem_valid=1 with mem_addr=addr, mem_wdata={4{b}}, mem_wstrb=1<<addr[1:0], all stable until mem_ready.
    - On handshake: addr += 1 (mod 2^32, wraps 0xFFFFFFFF->0), remaining -= 1.
    - remaining reaches 0 -> CSUM; else -> DATA.
    - mem_ready asserted in the same cycle mem_valid first rises completes that write; 1 byte per 2 cycles minimum.
  - CSUM: on byte c -> REPLY 0x06 if c == checksum, else 0x15. Payload writes are never rolled back.
  - REPLY: tx_available=1, tx_data stable until tx_ack; on tx_ack -> IDLE, or -> GO if kind=G.
  - GO: go_addr <= addr, go_valid=1 for exactly one cycle -> IDLE.
- Timeout:
  - Counter runs in ADDR, LEN, DATA, CSUM only; cleared on every rx_ack and on entering those states.
  - Frozen in WRITE and REPLY (no stall-induced abort).
  - Counter reaching TIMEOUT_CYCLES -> IDLE with no reply and no go_valid; partial payload writes stand.
- Rx byte and timeout in the same cycle: the byte wins, counter clears.
- busy is derived from registered state; no combinational path from rx_data to any output other than through registers.

Test Plan:
- Frame 57 00 01 00 00 03 00 AA BB CC 31 → three writes:
  - addr 0x100 wstrb 0001 wdata AAAAAAAA
  - addr 0x101 wstrb 0010 wdata BBBBBBBB
  - addr 0x102 wstrb 0100 wdata CCCCCCCC
  - then tx_data 0x06, then IDLE.
- Same frame with csum 0x00 → same three writes, reply 0x15.
- mem_ready held low 20 cycles on the first write → mem_addr/wdata stable, rx_pop=0 throughout, no timeout; write completes when ready rises.
- tx_ack held low 10 cycles during reply → tx_available and tx_data=0x06 held.
- Frame 47 00 00 00 80 → reply 0x06 accepted, then go_valid pulse of exactly 1 cycle, go_addr=0x80000000.
- Edge cases:
  - Byte 0x41 → reply 0x3F.
  - 57 FF FF FF FF 02 00 11 22 33 → writes at 0xFFFFFFFF (wstrb 1000) then 0x00000000 (wstrb 0001), reply 0x06.
  - len=0 frame 57 00 00 00 00 00 00 00 → no writes, reply 0x06.
  - With TIMEOUT_CYCLES=50, send 57 01 then idle 50 cycles → IDLE, no reply, busy=0.
  - rst pulsed during WRITE → mem_valid=0 next cycle.
